// File: rtl/memfifo_test_checker.sv
// memfifo_test_checker: receive-side checker for the memfifo test-pattern stream.
// Acquires frame alignment on the 16-bit FIFO output, recomputes the running
// counter and per-frame checksum, and reports lock, good frames and errors.
// Ports:
//   ifclk, reset (async active-low), clr (sync clear)
//   DI[15:0], DI_valid, DI_ready : input word stream (never back-pressures)
//   locked, err, err_cnt, frame_cnt, state : registered status outputs
module memfifo_test_checker #(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned FRM_W       = 32
) (
  input  logic             ifclk,
  input  logic             reset,
  input  logic             clr,
  input  logic [15:0]      DI,
  input  logic             DI_valid,
  output logic             DI_ready,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [FRM_W-1:0] frame_cnt,
  output logic [1:0]       state
);

  localparam int unsigned RUN_W    = $clog2(LOCK_FRAMES + 1);
  localparam logic [13:0] CS_INIT  = 14'd47;
  localparam logic [6:0]  CNT_STEP = 7'd111;
  // Counter advance across two counted bytes: 2*111 mod 128
  localparam logic [6:0]  CNT_WORD = 7'd94;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    SEED  = 2'd1,
    CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [13:0]      cs_q, cs_d;
  logic [2:0]       idx_q, idx_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             locked_q, locked_d;
  logic             ready_q;

  logic        accept;
  logic        last_word;
  logic [13:0] cs_lo, cs_word, cs_seed;
  logic [7:0]  exp_lo, exp_hi;
  logic        seed_ok, check_ok;

  assign accept    = DI_valid && ready_q && !clr;
  assign last_word = (idx_q == 3'd7);

  // Expected bytes for the current word; word 7 carries b14 and the folded checksum
  assign cs_lo    = cs_q + 14'(DI[7:0]);
  assign cs_word  = cs_lo + 14'(DI[15:8]);
  assign cs_seed  = CS_INIT + 14'(DI[7:0]) + 14'(DI[15:8]);
  assign exp_lo   = {last_word, cnt_q};
  assign exp_hi   = last_word ? {1'b1, cs_lo[6:0] ^ cs_lo[13:7]}
                              : {1'b1, 7'(cnt_q + CNT_STEP)};
  assign seed_ok  = !DI[7] && (DI[15:8] == {1'b1, 7'(DI[6:0] + CNT_STEP)});
  assign check_ok = (DI[7:0] == exp_lo) && (DI[15:8] == exp_hi);

  // Next-state and status computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cs_d        = cs_q;
    idx_d       = idx_q;
    run_d       = run_q;
    err_d       = 1'b0;
    err_cnt_d   = err_cnt_q;
    frame_cnt_d = frame_cnt_q;

    if (clr) begin
      state_d     = HUNT;
      cnt_d       = 7'd0;
      cs_d        = CS_INIT;
      idx_d       = 3'd0;
      run_d       = '0;
      err_cnt_d   = '0;
      frame_cnt_d = '0;
    end else if (accept) begin
      unique case (state_q)
        HUNT: begin
          if (DI[7] && DI[15]) state_d = SEED;
        end
        SEED: begin
          if (seed_ok) begin
            state_d = CHECK;
            cnt_d   = DI[6:0] + CNT_WORD;
            cs_d    = cs_seed;
            idx_d   = 3'd1;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
            run_d   = '0;
          end
        end
        CHECK: begin
          if (!check_ok) begin
            state_d = HUNT;
            err_d   = 1'b1;
            run_d   = '0;
          end else if (last_word) begin
            cnt_d       = cnt_q + CNT_STEP;
            cs_d        = CS_INIT;
            idx_d       = 3'd0;
            frame_cnt_d = frame_cnt_q + FRM_W'(1);
            if (run_q != RUN_W'(LOCK_FRAMES)) run_d = run_q + RUN_W'(1);
          end else begin
            cnt_d = cnt_q + CNT_WORD;
            cs_d  = cs_word;
            idx_d = idx_q + 3'd1;
          end
        end
        default: state_d = HUNT;
      endcase
      if (err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);
    end

    locked_d = (run_d == RUN_W'(LOCK_FRAMES));
  end

  // State and output registers
  always_ff @(posedge ifclk or negedge reset) begin
    if (!reset) begin
      state_q     <= HUNT;
      cnt_q       <= 7'd0;
      cs_q        <= CS_INIT;
      idx_q       <= 3'd0;
      run_q       <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
      frame_cnt_q <= '0;
      locked_q    <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cs_q        <= cs_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      locked_q    <= locked_d;
      ready_q     <= 1'b1;
    end
  end

  assign DI_ready  = ready_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_memfifo_test_checker.sv
// Directed testbench for memfifo_test_checker with a local pattern-generator model.
module tb_memfifo_test_checker;

  localparam int unsigned ERR_W = 4;
  localparam int unsigned FRM_W = 4;

  logic             ifclk;
  logic             reset;
  logic             clr;
  logic [15:0]      DI;
  logic             DI_valid;
  logic             DI_ready;
  logic             locked;
  logic             err;
  logic [ERR_W-1:0] err_cnt;
  logic [FRM_W-1:0] frame_cnt;
  logic [1:0]       state;

  memfifo_test_checker #(
    .LOCK_FRAMES(2),
    .ERR_W      (ERR_W),
    .FRM_W      (FRM_W)
  ) dut (
    .ifclk    (ifclk),
    .reset    (reset),
    .clr      (clr),
    .DI       (DI),
    .DI_valid (DI_valid),
    .DI_ready (DI_ready),
    .locked   (locked),
    .err      (err),
    .err_cnt  (err_cnt),
    .frame_cnt(frame_cnt),
    .state    (state)
  );

  initial ifclk = 1'b0;
  always #5 ifclk = ~ifclk;

  int n_checks = 0;
  int n_fail   = 0;
  int err_pulses = 0;

  // err is a one-cycle pulse, so one sample per cycle counts each pulse once
  always @(negedge ifclk) if (err === 1'b1) err_pulses <= err_pulses + 1;

  // Generator model state
  logic [6:0]  g_cnt;
  logic [13:0] g_cs;
  int          g_b;

  task automatic gen_reset();
    g_cnt = 7'd0;
    g_cs  = 14'd47;
    g_b   = 0;
  endtask

  task automatic next_byte(output logic [7:0] b);
    if (g_b < 15) begin
      b     = {((g_b % 2) == 1) || (g_b == 14), g_cnt};
      g_cs  = g_cs + 14'(b);
      g_cnt = g_cnt + 7'd111;
    end else begin
      b    = {1'b1, g_cs[6:0] ^ g_cs[13:7]};
      g_cs = 14'd47;
    end
    g_b = (g_b + 1) % 16;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w, input int gap);
    repeat (gap) begin
      @(negedge ifclk);
      DI_valid = 1'b0;
    end
    @(negedge ifclk);
    DI       = w;
    DI_valid = 1'b1;
    @(posedge ifclk);
    #1;
    DI_valid = 1'b0;
  endtask

  // Send n generator words; byte cbyte of the frame (0..15) is XORed with mask
  task automatic send_gen(input int n, input int cbyte, input logic [7:0] mask,
                          input int maxgap);
    logic [7:0] b0, b1;
    int bi, gap;
    for (int i = 0; i < n; i++) begin
      bi = g_b;
      next_byte(b0);
      if (bi == cbyte) b0 = b0 ^ mask;
      bi = g_b;
      next_byte(b1);
      if (bi == cbyte) b1 = b1 ^ mask;
      gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
      send({b1, b0}, gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at time %0t", $time);
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    reset    = 1'b0;
    clr      = 1'b0;
    DI       = 16'h0000;
    DI_valid = 1'b0;
    gen_reset();

    // Reset state
    repeat (3) @(posedge ifclk);
    #1;
    check("rst_ready", 32'(DI_ready), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_frame_cnt", 32'(frame_cnt), 0);
    check("rst_state", 32'(state), 0);
    @(negedge ifclk);
    reset = 1'b1;
    @(posedge ifclk);
    #1;
    check("ready_after_rst", 32'(DI_ready), 1);

    // Acquisition and 10 clean frames
    base = err_pulses;
    send(16'h8080, 0);
    check("hunt_to_seed", 32'(state), 1);
    gen_reset();
    send_gen(8, -1, 8'h00, 0);
    check("f1_frame_cnt", 32'(frame_cnt), 1);
    check("f1_locked", 32'(locked), 0);
    check("f1_state", 32'(state), 2);
    send_gen(8, -1, 8'h00, 0);
    check("f2_frame_cnt", 32'(frame_cnt), 2);
    check("f2_locked", 32'(locked), 1);
    send_gen(64, -1, 8'h00, 0);
    check("f10_frame_cnt", 32'(frame_cnt), 10);
    check("f10_locked", 32'(locked), 1);
    check("clean_no_err", 32'(err_pulses - base), 0);

    // Flip bit 0 of b5: error seen right after word 2
    base = err_pulses;
    send_gen(3, 5, 8'h01, 0);
    check("b5_err_pulse", 32'(err), 1);
    check("b5_err_cnt", 32'(err_cnt), 1);
    check("b5_locked", 32'(locked), 0);
    check("b5_state", 32'(state), 0);
    send_gen(5, -1, 8'h00, 0);
    check("b5_resync_seed", 32'(state), 1);
    check("b5_one_pulse", 32'(err_pulses - base), 1);
    send_gen(8, -1, 8'h00, 0);
    check("relock1_frame_cnt", 32'(frame_cnt), 11);
    check("relock1_locked", 32'(locked), 0);
    send_gen(8, -1, 8'h00, 0);
    check("relock2_frame_cnt", 32'(frame_cnt), 12);
    check("relock2_locked", 32'(locked), 1);

    // Corrupt the b15 checksum byte
    base = err_pulses;
    send_gen(7, -1, 8'h00, 0);
    send_gen(1, 15, 8'h01, 0);
    check("cs_err_pulse", 32'(err), 1);
    check("cs_frame_cnt_held", 32'(frame_cnt), 12);
    check("cs_err_cnt", 32'(err_cnt), 2);
    check("cs_state", 32'(state), 0);
    send_gen(8, -1, 8'h00, 0);
    check("cs_resync_seed", 32'(state), 1);
    send_gen(16, -1, 8'h00, 0);
    check("cs_relock_frame_cnt", 32'(frame_cnt), 14);
    check("cs_relock_locked", 32'(locked), 1);
    send_gen(8, -1, 8'h00, 0);
    check("pre_wrap_frame_cnt", 32'(frame_cnt), 15);
    send_gen(8, -1, 8'h00, 0);
    check("wrap_frame_cnt", 32'(frame_cnt), 0);
    check("wrap_locked", 32'(locked), 1);
    check("cs_one_pulse", 32'(err_pulses - base), 1);

    // Random idle gaps in a clean stream
    base = err_pulses;
    send_gen(24, -1, 8'h00, 5);
    repeat (4) @(posedge ifclk);
    #1;
    check("gap_frame_cnt", 32'(frame_cnt), 3);
    check("gap_locked", 32'(locked), 1);
    check("gap_state", 32'(state), 2);
    check("gap_no_err", 32'(err_pulses - base), 0);

    // Synchronous clear with a word present
    @(negedge ifclk);
    clr      = 1'b1;
    DI       = 16'h8080;
    DI_valid = 1'b1;
    @(posedge ifclk);
    #1;
    clr      = 1'b0;
    DI_valid = 1'b0;
    check("clr_state", 32'(state), 0);
    check("clr_frame_cnt", 32'(frame_cnt), 0);
    check("clr_err_cnt", 32'(err_cnt), 0);
    check("clr_locked", 32'(locked), 0);
    check("clr_ready", 32'(DI_ready), 1);

    // Saturating error counter: each sync word followed by a bad seed word is one error
    base = err_pulses;
    for (int i = 1; i <= 20; i++) begin
      send(16'h8080, 0);
      send(16'h8080, 0);
      check("sat_err_pulse", 32'(err), 1);
      check("sat_err_cnt", 32'(err_cnt), (i < 15) ? 32'(i) : 32'd15);
    end
    repeat (2) @(posedge ifclk);
    #1;
    check("sat_pulses", 32'(err_pulses - base), 20);

    // Asynchronous reset mid-frame, then resume the stream mid-frame
    send(16'h8080, 0);
    gen_reset();
    send_gen(16, -1, 8'h00, 0);
    check("pre_async_locked", 32'(locked), 1);
    send_gen(3, -1, 8'h00, 0);
    @(negedge ifclk);
    #2;
    reset = 1'b0;
    #1;
    check("async_ready", 32'(DI_ready), 0);
    check("async_locked", 32'(locked), 0);
    check("async_state", 32'(state), 0);
    check("async_frame_cnt", 32'(frame_cnt), 0);
    check("async_err_cnt", 32'(err_cnt), 0);
    repeat (3) @(posedge ifclk);
    #1;
    check("async_ready_held", 32'(DI_ready), 0);
    @(negedge ifclk);
    reset = 1'b1;
    @(posedge ifclk);
    #1;
    check("async_ready_rise", 32'(DI_ready), 1);
    base = err_pulses;
    send_gen(5, -1, 8'h00, 0);
    check("resume_seed", 32'(state), 1);
    check("resume_no_err", 32'(err_pulses - base), 0);
    send_gen(16, -1, 8'h00, 0);
    check("resume_frame_cnt", 32'(frame_cnt), 2);
    check("resume_locked", 32'(locked), 1);
    check("resume_no_err2", 32'(err_pulses - base), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
